// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 constants and sequencer state encoding
package fp_pkg;
    localparam int FP_W      = 32;
    localparam int FP_SIGN_W = 1;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT
    } seq_state_t;
endpackage

// File: rtl/fpacc_timer.sv
// rtl/fpacc_timer.sv - loadable up-counter with zero and terminal-count flags
module fpacc_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero,
    output logic o_tc
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] TC = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    // Holds at terminal count so a long wait can never wrap back to zero.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_tc   = (r_cnt == TC);
endmodule

// File: rtl/fpacc_seq.sv
// rtl/fpacc_seq.sv - FP32 stream accumulator driving an external multi-cycle adder
module fpacc_seq
    import fp_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [FP_W-1:0]  i_in_data,
    input  logic             i_in_last,
    output logic             o_add_start,
    output logic [FP_W-1:0]  o_add_a,
    output logic [FP_W-1:0]  o_add_b,
    input  logic [FP_W-1:0]  i_add_sum,
    input  logic             i_add_done,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [FP_W-1:0]  o_out_data,
    output logic [CNT_W-1:0] o_out_count,
    output logic             o_out_err
);
    seq_state_t        r_state;
    logic [FP_W-1:0]   r_acc;
    logic [FP_W-1:0]   r_op;
    logic              r_last_p;
    logic              r_first;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              r_in_ready;
    logic              r_add_start;
    logic              r_out_valid;

    logic              w_timer_zero;
    logic              w_timer_tc;

    fpacc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (r_state == ST_ISSUE),
        .i_en    (r_state == ST_WAIT),
        .o_zero  (w_timer_zero),
        .o_tc    (w_timer_tc)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= FP_POS_ZERO;
            r_op        <= FP_POS_ZERO;
            r_last_p    <= 1'b0;
            r_first     <= 1'b1;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_add_start <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_add_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        if (r_count != '1) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        r_last_p <= i_in_last;
                        if (r_first) begin
                            r_acc   <= i_in_data;
                            r_first <= 1'b0;
                            if (i_in_last) begin
                                r_state     <= ST_RESULT;
                                r_in_ready  <= 1'b0;
                                r_out_valid <= 1'b1;
                            end
                        end else begin
                            r_op        <= i_in_data;
                            r_state     <= ST_ISSUE;
                            r_in_ready  <= 1'b0;
                            r_add_start <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The first WAIT cycle still shows the previous op's done level.
                    if (i_add_done && !w_timer_zero) begin
                        r_acc <= i_add_sum;
                        if (r_last_p) begin
                            r_state     <= ST_RESULT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_in_ready <= 1'b1;
                        end
                    end else if (w_timer_tc) begin
                        r_err       <= 1'b1;
                        r_state     <= ST_RESULT;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (i_out_ready) begin
                        r_state     <= ST_IDLE;
                        r_first     <= 1'b1;
                        r_count     <= '0;
                        r_err       <= 1'b0;
                        r_acc       <= FP_POS_ZERO;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_add_start = r_add_start;
    assign o_add_a     = r_acc;
    assign o_add_b     = r_op;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_acc;
    assign o_out_count = r_count;
    assign o_out_err   = r_err;
endmodule

// File: tb/tb_fpacc_seq.sv
// tb/tb_fpacc_seq.sv - scoreboard bench for fpacc_seq with a behavioural adder stub
module tb_fpacc_seq;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        logic             e;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic [31:0]      in_data   = 32'h0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic             add_done  = 1'b0;
    logic [31:0]      add_sum   = 32'h0;
    logic             in_ready;
    logic             add_start;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_start = 0;
    int lat = 5;
    bit never = 1'b0;
    bit preset = 1'b0;
    bit sum_const = 1'b0;

    exp_t        exp_q[$];
    logic [63:0] st_q[$];

    fpacc_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_last   (in_last),
        .o_add_start (add_start),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .i_add_done  (add_done),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_count (out_count),
        .o_out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
        return sum_const ? 32'h4040_0000 : a + b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s got=none want=event t=%0t", name, $time);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_add_start"}, add_start, 0);
        chk({tag, "_add_ab"}, {add_a, add_b}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_fields"}, {out_data, out_count, out_err}, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Adder stub: done drops one cycle after start, rises lat cycles after start.
    initial begin : stub
        bit busy;
        int n;
        logic [31:0] a_l, b_l;
        busy = 0;
        n = 0;
        a_l = 0;
        b_l = 0;
        forever begin
            @(posedge clk);
            if (preset) begin
                add_done <= 1'b1;
                add_sum  <= 32'hDEAD_BEEF;
                busy = 0;
            end else if (never) begin
                add_done <= 1'b0;
                busy = 0;
            end else if (add_start) begin
                busy = 1;
                n = 0;
                a_l = add_a;
                b_l = add_b;
            end else if (busy) begin
                n++;
                if (n == 1) add_done <= 1'b0;
                if (n == lat) begin
                    add_done <= 1'b1;
                    add_sum  <= stub_sum(a_l, b_l);
                    busy = 0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t cur;
        bit have;
        have = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (add_start) begin
                last_start = cyc;
                if (st_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_start got=%h want=no_start", {add_a, add_b});
                end else begin
                    chk("start_ab", {add_a, add_b}, st_q.pop_front());
                end
            end
            if (out_valid) begin
                chk("in_ready_in_result", in_ready, 0);
                if (!have) begin
                    have = 1;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_result got=%h want=no_result", out_data);
                        cur = {out_data, out_count, out_err};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("out_data", out_data, cur.d);
                        chk("out_count", out_count, cur.c);
                        chk("out_err", out_err, cur.e);
                    end
                end else begin
                    chk("result_stable", {out_data, out_count, out_err}, cur);
                end
                if (out_ready) have = 0;
            end else begin
                have = 0;
            end
        end
    end

    task automatic send_op(input logic [31:0] d, input logic l);
        int w;
        w = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) fail("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_stream(input logic [31:0] ops[$], input int hold,
                              input bit hold_valid, input int exp_lat);
        exp_t e;
        logic [31:0] acc;
        int w;
        acc = ops[0];
        e = '0;
        for (int i = 1; i < ops.size(); i++) begin
            st_q.push_back({acc, ops[i]});
            if (never) begin
                e.e = 1'b1;
                break;
            end
            acc = stub_sum(acc, ops[i]);
        end
        e.d = acc;
        e.c = CNT_W'((ops.size() > MAXC) ? MAXC : ops.size());
        exp_q.push_back(e);
        for (int i = 0; i < ops.size(); i++) send_op(ops[i], i == ops.size() - 1);
        w = 0;
        @(negedge clk);
        if (ops.size() == 1) chk("single_latency", out_valid, 1);
        while (!out_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) fail("result_wait");
        else if (exp_lat > 0) chk("result_latency", cyc - last_start, exp_lat);
        if (hold_valid) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b1;
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int n;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        sum_const = 1'b1;
        lat = 5;
        q.delete(); q.push_back(32'h3F80_0000); q.push_back(32'h4000_0000);
        run_stream(q, 1, 0, 7);
        sum_const = 1'b0;

        q.delete(); q.push_back(32'hC120_0000);
        run_stream(q, 0, 0, -1);

        preset = 1'b1;
        @(posedge clk);
        #1 preset = 1'b0;
        lat = 3;
        q.delete(); repeat (3) q.push_back($urandom);
        run_stream(q, 0, 0, -1);

        never = 1'b1;
        q.delete(); q.push_back(32'h1234_5678); q.push_back(32'h3F80_0000);
        run_stream(q, 0, 0, 9);
        never = 1'b0;

        lat = 4;
        q.delete(); q.push_back($urandom); q.push_back($urandom);
        run_stream(q, 10, 1, -1);
        q.delete(); q.push_back(32'h4120_0000);
        run_stream(q, 2, 0, -1);

        lat = 5;
        st_q.push_back({32'h4080_0000, 32'h40A0_0000});
        send_op(32'h4080_0000, 1'b0);
        send_op(32'h40A0_0000, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_after_stale_done", {in_ready, out_valid}, 2'b10);
        q.delete(); q.push_back(32'h3F00_0000); q.push_back(32'h3E80_0000);
        run_stream(q, 0, 0, 7);

        for (int s = 0; s < 8; s++) begin
            lat = $urandom_range(2, 6);
            n = $urandom_range(1, 9);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back($urandom);
            run_stream(q, $urandom_range(0, 3), 0, (n > 1) ? lat + 2 : -1);
        end

        repeat (3) @(negedge clk);
        chk("start_queue_drained", st_q.size(), 0);
        chk("result_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
